// File: rtl/kv_store_mem.sv
// Key/value cell array: combinational lookup/free-slot search over registered cells,
// single-cycle write/delete addressed by a one-hot index, with occupancy count and error pulse.
module kv_store_mem #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 32,
  localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   write_in,
  input  logic                   delete_in,
  input  logic [NUM_ENTRIES-1:0] idx_in,
  output logic                   hit,
  output logic [NUM_ENTRIES-1:0] hit_idx,
  output logic [VALUE_WIDTH-1:0] value_out,
  output logic [NUM_ENTRIES-1:0] free_idx,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output logic                   err
);

  localparam logic [NUM_ENTRIES-1:0] ONE_N = NUM_ENTRIES'(1);

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [KEY_WIDTH-1:0]   r_key   [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] r_value [NUM_ENTRIES];
  logic [CNT_W-1:0]       r_count;
  logic                   r_err;

  logic [NUM_ENTRIES-1:0] w_match;
  logic                   w_idx_onehot;
  logic                   w_sel_valid;
  logic                   w_do_write;
  logic                   w_do_delete;
  logic                   w_illegal;

  // Key compare against every valid cell; invalid cells are masked out.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_match[i] = r_valid[i] && (r_key[i] == key_in);
    end
  end

  // x & (~x + 1) isolates the lowest set bit, giving lowest-index priority.
  assign hit_idx  = w_match & (~w_match + ONE_N);
  assign hit      = |w_match;
  assign free_idx = ~r_valid & (r_valid + ONE_N);

  always_comb begin
    value_out = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (hit_idx[i]) value_out = value_out | r_value[i];
    end
  end

  assign w_idx_onehot = (idx_in != '0) && ((idx_in & (idx_in - ONE_N)) == '0);
  assign w_sel_valid  = |(idx_in & r_valid);
  assign w_do_write   = write_in && !delete_in && w_idx_onehot;
  assign w_do_delete  = delete_in && !write_in && w_idx_onehot && w_sel_valid;
  assign w_illegal    = (write_in || delete_in) && !w_do_write && !w_do_delete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_key[i]   <= '0;
        r_value[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (idx_in[i] && w_do_write) begin
          r_valid[i] <= 1'b1;
          r_key[i]   <= key_in;
          r_value[i] <= value_in;
        end else if (idx_in[i] && w_do_delete) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Overwriting an already-valid cell leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_do_write && !w_sel_valid) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_delete) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign count = r_count;
  assign err   = r_err;
  assign full  = (r_count == CNT_W'(NUM_ENTRIES));
  assign empty = (r_count == '0);

endmodule
